instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Assembler-side counterpart of the 9-bit instruction decode.
//  Accepts one instruction request per valid/ready handshake, either a run-type op or a put-type immediate.
//  Packs each request into the 9-bit instruction word and writes it sequentially into instruction memory.
//  Sits between the testbench/boot program source and the instruction ROM write port.
// PARAMETERS
//  AW        12   instruction-memory address width; matches the instr ROM counter width
//  BASE_ADDR 0    first write address after start
//  DEPTH     4096 max words per load session; must be 1..2**AW
// PORTS
//  clk        in  1   single clock; all logic on rising edge
//  reset_n    in  1   synchronous active-low reset
//  start      in  1   1-cycle pulse: begin new load session
//  finish     in  1   1-cycle pulse: close session
//  in_valid   in  1   request valid
//  in_ready   out 1   encoder can accept request this cycle
//  in_kind    in  1   0=run type (op), 1=put type (immediate)
//  in_op      in  5   run-type opcode; legal 5'h00..5'h10
//  in_value   in  8   put-type payload (also li payload when expansion enabled)
//  wr_en      out 1   instruction-memory write strobe
//  wr_addr    out AW  write address
//  wr_data    out 9   encoded instruction word
//  word_count out AW+1 words written this session
//  done       out 1   session closed cleanly (sticky until start/reset)
//  error      out 1   illegal op / overflow seen (sticky until start/reset)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE.
//   All outputs are 0: in_ready, wr_en, wr_addr, wr_data, word_count, done, error.
//   Reset mid-session aborts with no further writes.
//  States: IDLE, LOAD, EXP (expansion 2nd word), FULL, DONE, ERR.
//  IDLE/DONE/ERR --start--> LOAD:
//   next addr=BASE_ADDR, word_count=0, done=0, error=0.
//  start in any state restarts the session identically; a same-cycle handshake is dropped.
//  in_ready=1 only in LOAD with word_count<DEPTH; 0 in every other state.
//  Accept = in_valid & in_ready. Write appears the cycle after accept:
//   wr_en high for exactly 1 cycle; wr_data/wr_addr are registered.
//  Encoding:
//   put: wr_data={in_value,1'b1}
//   run: wr_data={3'b000,in_op,1'b0}
//  Illegal op (in_op>5'h10, run type) is accepted:
//   no write, error=1, state->ERR.
//  After each write: wr_addr+=1 modulo 2**AW (wraps 2**AW-1 -> 0); word_count+=1.
//  When word_count reaches DEPTH: state->FULL, in_ready=0.
//   in_valid while FULL sets error=1 (no write); state stays FULL.
//  finish in LOAD/FULL/EXP -> DONE, done=1 next cycle.
//   finish with a same-cycle accept: the word is still written, then DONE.
//   finish during EXP: the 2nd word is written first.
//  finish in IDLE/DONE/ERR: ignored.
//  Back-to-back accepts sustain 1 word/cycle in LOAD.
// CONFIGURATION
//  ENC_LI_EXPAND_EN defined:
//   run op 5'h00 (load immediate) expands to two words: {in_value,1'b1} at A, then 9'h000 at A+1.
//   Encoder enters EXP for 1 cycle with in_ready=0; word_count+=2.
//   If fewer than 2 slots remain: no write, error=1, state->ERR.
//  ENC_LI_EXPAND_EN undefined:
//   op 5'h00 emits the single word 9'h000; in_value is ignored; EXP is unreachable.
// TESTING
//  1. reset_n=0 2 cycles -> all outputs 0; start -> in_ready=1 next cycle.
//  2. start; put 8'hA5, then op 5'h03 -> wr_data 9'h14B@0, 9'h006@1; word_count=2.
//  3. Stream of 4 back-to-back valids -> 4 consecutive wr_en cycles, addrs 0..3.
//  4. op 5'h11 -> no wr_en, error=1, in_ready=0 until next start.
//  5. DEPTH=4, BASE_ADDR=2**AW-2: 4 writes -> addrs FFE,FFF,000,001; FULL; 5th valid -> error=1.
//  6. ENC_LI_EXPAND_EN: li value 8'h3C -> 9'h079 then 9'h000; in_ready low 1 cycle; finish same cycle -> both writes, done=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs run-type ops and put-type immediates into 9-bit instruction words and
// writes them one after another into the instruction memory write port.
// A load session begins with a start pulse and ends with a finish pulse.
// Optional feature macro: ENC_LI_EXPAND_EN. When it is defined, op 5'h00
// (load immediate) becomes the two words {value,1} and 9'h000. When it is not
// defined, op 5'h00 encodes as the single word 9'h000.
module instr_encoder_loader #(
  parameter int AW        = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_kind,
  input  logic [4:0]    in_op,
  input  logic [7:0]    in_value,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [8:0]    wr_data,
  output logic [AW:0]   word_count,
  output logic          done,
  output logic          error
);

  localparam logic [AW-1:0] BASE_A  = AW'(BASE_ADDR);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [4:0]    MAX_OP  = 5'h10;

  typedef enum logic [2:0] {IDLE, LOAD, EXP, FULL, DONE, ERR} state_t;

  state_t        state;
  logic [AW-1:0] next_addr;
  logic [AW:0]   count_inc;
  logic          accept;
  logic          is_illegal;
  logic [8:0]    encoded;
`ifdef ENC_LI_EXPAND_EN
  logic          is_li;
  logic          fin_pending;
  logic          room_for_two;
`endif

  // Requests are taken only while loading and while the session still has room.
  assign in_ready   = (state == LOAD) && (word_count < DEPTH_W);
  assign accept     = in_valid && in_ready;
  assign is_illegal = !in_kind && (in_op > MAX_OP);
  assign encoded    = in_kind ? {in_value, 1'b1} : {3'b000, in_op, 1'b0};
  assign count_inc  = word_count + (AW+1)'(1);
`ifdef ENC_LI_EXPAND_EN
  assign is_li        = !in_kind && (in_op == 5'h00);
  assign room_for_two = (DEPTH_W - word_count) >= (AW+1)'(2);
`endif

  // Session state machine; all outputs are registered here, and a start pulse
  // overrides everything else so a same-cycle request is simply dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      next_addr  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef ENC_LI_EXPAND_EN
      fin_pending <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        state      <= LOAD;
        next_addr  <= BASE_A;
        word_count <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
`ifdef ENC_LI_EXPAND_EN
        fin_pending <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (is_illegal) begin
                error <= 1'b1;
                state <= ERR;
              end
`ifdef ENC_LI_EXPAND_EN
              else if (is_li) begin
                if (!room_for_two) begin
                  error <= 1'b1;
                  state <= ERR;
                end else begin
                  wr_en       <= 1'b1;
                  wr_addr     <= next_addr;
                  wr_data     <= {in_value, 1'b1};
                  next_addr   <= next_addr + AW'(1);
                  word_count  <= count_inc;
                  fin_pending <= finish;
                  state       <= EXP;
                end
              end
`endif
              else begin
                wr_en      <= 1'b1;
                wr_addr    <= next_addr;
                wr_data    <= encoded;
                next_addr  <= next_addr + AW'(1);
                word_count <= count_inc;
                if (finish) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else if (count_inc == DEPTH_W) begin
                  state <= FULL;
                end
              end
            end else if (finish) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
`ifdef ENC_LI_EXPAND_EN
          EXP: begin
            wr_en       <= 1'b1;
            wr_addr     <= next_addr;
            wr_data     <= 9'h000;
            next_addr   <= next_addr + AW'(1);
            word_count  <= count_inc;
            fin_pending <= 1'b0;
            if (finish || fin_pending) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (count_inc == DEPTH_W) begin
              state <= FULL;
            end else begin
              state <= LOAD;
            end
          end
`endif
          FULL: begin
            if (in_valid) begin
              error <= 1'b1;
            end
            if (finish) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
// Directed bench: a main instance (BASE_ADDR 0, DEPTH 4096) and a small
// instance (BASE_ADDR 12'hFFE, DEPTH 4) share the same stimulus.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_kind;
  logic [4:0]  in_op;
  logic [7:0]  in_value;

  logic        in_ready,   s_in_ready;
  logic        wr_en,      s_wr_en;
  logic [11:0] wr_addr,    s_wr_addr;
  logic [8:0]  wr_data,    s_wr_data;
  logic [12:0] word_count, s_word_count;
  logic        done,       s_done;
  logic        error,      s_error;

  int total_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic       kind;
    logic [4:0] op;
    logic [7:0] value;
    logic [8:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  instr_encoder_loader #(.AW(12), .BASE_ADDR(0), .DEPTH(4096)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_op(in_op), .in_value(in_value), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .word_count(word_count), .done(done), .error(error)
  );

  instr_encoder_loader #(.AW(12), .BASE_ADDR(4094), .DEPTH(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_kind(in_kind),
    .in_op(in_op), .in_value(in_value), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .word_count(s_word_count), .done(s_done), .error(s_error)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request onto the input bus
  task automatic applyStimulus(input logic valid, input logic kind,
                               input logic [4:0] op, input logic [7:0] value);
    in_valid = valid;
    in_kind  = kind;
    in_op    = op;
    in_value = value;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    else
      pass_count++;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'h00, 8'hA5, 9'h14B};
    vecs[1] = '{1'b0, 5'h03, 8'h00, 9'h006};
    vecs[2] = '{1'b1, 5'h00, 8'h00, 9'h001};
    vecs[3] = '{1'b0, 5'h10, 8'h77, 9'h020};
    vecs[4] = '{1'b1, 5'h00, 8'hFF, 9'h1FF};
    vecs[5] = '{1'b0, 5'h01, 8'h00, 9'h002};

    reset_n = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_in_ready",   in_ready,   0);
    checkOutput("rst_wr_en",      wr_en,      0);
    checkOutput("rst_wr_addr",    wr_addr,    0);
    checkOutput("rst_wr_data",    wr_data,    0);
    checkOutput("rst_word_count", word_count, 0);
    checkOutput("rst_done",       done,       0);
    checkOutput("rst_error",      error,      0);
    checkOutput("rst_s_in_ready", s_in_ready, 0);

    // Session with a back-to-back stream from the vector table
    reset_n = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_in_ready", in_ready, 1);
    checkOutput("start_wr_en",    wr_en,    0);
    applyStimulus(1'b1, vecs[0].kind, vecs[0].op, vecs[0].value);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("vec%0d_wr_en", i),   wr_en,      1);
      checkOutput($sformatf("vec%0d_wr_addr", i), wr_addr,    i);
      checkOutput($sformatf("vec%0d_wr_data", i), wr_data,    vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_count", i),   word_count, i + 1);
      if (i < 5)
        applyStimulus(1'b1, vecs[i+1].kind, vecs[i+1].op, vecs[i+1].value);
      else
        applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    end
    tick();
    checkOutput("idle_wr_en", wr_en, 0);
    checkOutput("idle_count", word_count, 6);

    // Finish together with an accept: word written, then closed
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h12);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("fin_wr_en",    wr_en,      1);
    checkOutput("fin_wr_addr",  wr_addr,    6);
    checkOutput("fin_wr_data",  wr_data,    9'h025);
    checkOutput("fin_done",     done,       1);
    checkOutput("fin_in_ready", in_ready,   0);
    checkOutput("fin_count",    word_count, 7);
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h34);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("done_ignore_wr_en", wr_en, 0);
    checkOutput("done_sticky",       done,  1);

    // Start with a same-cycle request: request dropped, counters cleared
    start = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h99);
    tick();
    start = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("restart_wr_en",    wr_en,      0);
    checkOutput("restart_done",     done,       0);
    checkOutput("restart_count",    word_count, 0);
    checkOutput("restart_in_ready", in_ready,   1);

`ifdef ENC_LI_EXPAND_EN
    // Load immediate expands to two words; finish rides along
    applyStimulus(1'b1, 1'b0, 5'h00, 8'h3C);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("li_w1_en",     wr_en,    1);
    checkOutput("li_w1_data",   wr_data,  9'h079);
    checkOutput("li_w1_addr",   wr_addr,  0);
    checkOutput("li_in_ready",  in_ready, 0);
    checkOutput("li_done_early", done,    0);
    tick();
    checkOutput("li_w2_en",    wr_en,      1);
    checkOutput("li_w2_data",  wr_data,    9'h000);
    checkOutput("li_w2_addr",  wr_addr,    1);
    checkOutput("li_count",    word_count, 2);
    checkOutput("li_done",     done,       1);
`else
    // Op 5'h00 is a plain single word and ignores the payload
    applyStimulus(1'b1, 1'b0, 5'h00, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("op0_wr_en",    wr_en,      1);
    checkOutput("op0_wr_data",  wr_data,    9'h000);
    checkOutput("op0_in_ready", in_ready,   1);
    checkOutput("op0_count",    word_count, 1);
    tick();
    checkOutput("op0_single",   wr_en,      0);
`endif

    // Illegal op: no write, error sticky, in_ready low until restart
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'h11, 8'h00);
    tick();
    checkOutput("ill_wr_en",    wr_en,    0);
    checkOutput("ill_error",    error,    1);
    checkOutput("ill_in_ready", in_ready, 0);
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h01);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("err_ignore_wr_en", wr_en,    0);
    checkOutput("err_in_ready",     in_ready, 0);
    checkOutput("err_sticky",       error,    1);

    // Small instance: address wrap, FULL and overflow
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_error", error, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 5'h00, 8'(8'h11 * (i + 1)));
      tick();
      checkOutput($sformatf("small%0d_wr_en", i),   s_wr_en,   1);
      checkOutput($sformatf("small%0d_wr_addr", i), s_wr_addr, (12'hFFE + i) & 12'hFFF);
      checkOutput($sformatf("small%0d_wr_data", i), s_wr_data, {8'(8'h11 * (i + 1)), 1'b1});
    end
    checkOutput("small_full_in_ready", s_in_ready,   0);
    checkOutput("small_full_count",    s_word_count, 4);
    checkOutput("small_full_error",    s_error,      0);
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("small_ovf_wr_en", s_wr_en, 0);
    checkOutput("small_ovf_error", s_error, 1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checkOutput("small_full_done", s_done, 1);

    // Reset in the middle of a session aborts the pending write
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'h00, 8'h66);
    reset_n = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 5'h00, 8'h00);
    checkOutput("midrst_wr_en",    wr_en,      0);
    checkOutput("midrst_count",    word_count, 0);
    checkOutput("midrst_in_ready", in_ready,   0);
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
